if_id_reg: RTL

IF_ID_REG -- requirements
Module: if_id_reg

---
 rtl/if_id_reg.sv | 68 ++++++
 1 files changed

// File: rtl/if_id_reg.sv
// if_id_reg: 2-entry skid buffer between fetch and decode, with a saturating decode-stall counter.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [63:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        flush,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready,
  output logic [1:0]  occupancy,
  output logic [31:0] stall_cnt
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [63:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic [31:0] head_inst_q, head_inst_d, skid_inst_q, skid_inst_d, stall_q, stall_d;
  logic        push, pop, load_in, load_skid, take_skid;
  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_pc_q   <= '0;
      head_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      stall_q     <= stall_d;
    end
  end
  // flush overrides every transition; a same-cycle pop is still a completed handshake
  always_comb begin
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (push ? ONE : EMPTY) :
              state_q == ONE   ? (push && !pop ? FULL : !push && pop ? EMPTY : ONE) :
              (pop ? ONE : FULL);
  end
  always_comb begin
    id_valid  = state_q != EMPTY;
    if_ready  = !rst && state_q != FULL;
    occupancy = state_q;
    id_pc     = head_pc_q;
    id_inst   = id_valid ? head_inst_q : NOP_INST;
    stall_cnt = stall_q;
  end
  always_comb begin
    load_in     = !flush && push && (state_q == EMPTY || pop);
    load_skid   = !flush && push && state_q == ONE && !pop;
    take_skid   = !flush && pop && state_q == FULL;
    head_pc_d   = take_skid ? skid_pc_q : load_in ? if_pc : head_pc_q;
    head_inst_d = take_skid ? skid_inst_q : load_in ? if_inst : head_inst_q;
    skid_pc_d   = load_skid ? if_pc : skid_pc_q;
    skid_inst_d = load_skid ? if_inst : skid_inst_q;
    stall_d     = (id_valid && !id_ready && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
  end
endmodule
